// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU data-memory port.
package cpu_mem_pkg;

  localparam int MEM_BYTES = 64;
  localparam int DATA_W    = 16;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    RMW_RD,
    RMW_WR,
    DONE
  } lsu_state_t;

  typedef enum logic [1:0] {
    FLT_NONE  = 2'b00,
    FLT_ALIGN = 2'b01,
    FLT_RANGE = 2'b10
  } lsu_fault_t;

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane helper for the LSU: picks a byte out of a big-endian word for loads
// and splices a new byte into a word for read-modify-write stores.
module lsu_byte_lane
  import cpu_mem_pkg::*;
(
  input  logic [DATA_W-1:0] word_i,
  input  logic              lane_i,
  input  logic              signed_i,
  input  logic [7:0]        wbyte_i,
  output logic [DATA_W-1:0] load_o,
  output logic [DATA_W-1:0] merge_o
);

  logic [7:0] selByte;

  // Even byte address is the high half of the word (big-endian).
  always_comb begin
    selByte = lane_i ? word_i[7:0] : word_i[15:8];
    load_o  = {{8{signed_i & selByte[7]}}, selByte};
    merge_o = lane_i ? {word_i[15:8], wbyte_i} : {wbyte_i, word_i[7:0]};
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the data-memory port with byte access,
// read-modify-write byte stores and alignment/range fault checks.
module load_store_unit #(
  parameter int MEM_BYTES = cpu_mem_pkg::MEM_BYTES,
  parameter int DATA_W    = cpu_mem_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic              req_signed,
  input  logic [15:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [1:0]        resp_fault,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);
  import cpu_mem_pkg::*;

  lsu_state_t        state_q, state_d;
  lsu_fault_t        fault_q, reqFault;
  logic              byte_q, signed_q;
  logic [15:0]       addr_q;
  logic [DATA_W-1:0] wdata_q, word_q, rdata_q;
  logic [DATA_W-1:0] laneWord, laneLoad, laneMerge;
  logic [16:0]       lastByte;
  logic [31:0]       alignedAddr;
  logic              accept;

  assign accept      = req_valid && (state_q == IDLE);
  assign alignedAddr = {16'd0, addr_q[15:1], 1'b0};
  assign laneWord    = (state_q == READ) ? mem_rdata : word_q;
  assign resp_rdata  = rdata_q;
  assign resp_fault  = fault_q;

  // Range is checked on the last byte touched and takes priority over alignment.
  always_comb begin
    lastByte = {1'b0, req_addr} + (req_byte ? 17'd0 : 17'd1);
    reqFault = FLT_NONE;
    if (lastByte >= 17'(MEM_BYTES)) begin
      reqFault = FLT_RANGE;
    end else if (!req_byte && req_addr[0]) begin
      reqFault = FLT_ALIGN;
    end
  end

  lsu_byte_lane u_lane (
    .word_i  (laneWord),
    .lane_i  (addr_q[0]),
    .signed_i(signed_q),
    .wbyte_i (wdata_q[7:0]),
    .load_o  (laneLoad),
    .merge_o (laneMerge)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (reqFault != FLT_NONE) begin
            state_d = DONE;
          end else if (!req_write) begin
            state_d = READ;
          end else if (req_byte) begin
            state_d = RMW_RD;
          end else begin
            state_d = WRITE;
          end
        end
      end
      READ, WRITE, RMW_WR: state_d = DONE;
      RMW_RD:              state_d = RMW_WR;
      DONE:                state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      IDLE: req_ready = 1'b1;
      READ, RMW_RD: begin
        mem_read = 1'b1;
        mem_addr = alignedAddr;
      end
      WRITE: begin
        mem_write = 1'b1;
        mem_addr  = alignedAddr;
        mem_wdata = wdata_q;
      end
      RMW_WR: begin
        mem_write = 1'b1;
        mem_addr  = alignedAddr;
        mem_wdata = laneMerge;
      end
      DONE:    resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Response fields only change on entry to DONE, so they hold between responses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      byte_q   <= 1'b0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      rdata_q  <= '0;
      fault_q  <= FLT_NONE;
    end else begin
      if (accept) begin
        byte_q   <= req_byte;
        signed_q <= req_signed;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        if (reqFault != FLT_NONE) begin
          rdata_q <= '0;
          fault_q <= reqFault;
        end
      end
      case (state_q)
        READ: begin
          rdata_q <= byte_q ? laneLoad : mem_rdata;
          fault_q <= FLT_NONE;
        end
        RMW_RD: word_q <= mem_rdata;
        WRITE, RMW_WR: begin
          rdata_q <= '0;
          fault_q <= FLT_NONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit with a byte-array data
// memory responder and a transaction-level reference model.
module tb_load_store_unit;

  localparam int MEM_BYTES = 64;

  typedef struct {
    logic [15:0] rdata;
    logic [1:0]  fault;
    int          lat;
    int          acc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_byte = 1'b0, req_signed = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, mem_read, mem_write;
  logic [15:0] resp_rdata, mem_wdata, mem_rdata;
  logic [1:0]  resp_fault;
  logic [31:0] mem_addr;

  logic [7:0]  mem    [MEM_BYTES];
  logic [7:0]  refMem [MEM_BYTES];
  exp_t        expQ[$];
  exp_t        monEntry;
  int          vecCount = 0, errCount = 0, protErrs = 0, memAccesses = 0, cyc = 0;
  bit          manualMode = 1'b1;
  logic [15:0] lastRdata = '0;
  logic [1:0]  lastFault = '0;
  int          lastLat = 0;

  load_store_unit #(.MEM_BYTES(MEM_BYTES), .DATA_W(16)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_byte  (req_byte),
    .req_signed(req_signed),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_fault(resp_fault),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Idle bus reads as a recognisable pattern so stray sampling shows up as bad data.
  assign mem_rdata = (mem_read && !mem_write && mem_addr < 32'(MEM_BYTES))
                   ? {mem[mem_addr[5:0]], mem[mem_addr[5:0] | 6'd1]} : 16'hDEAD;

  always @(posedge clock) begin
    if (mem_write && !mem_read && mem_addr < 32'(MEM_BYTES)) begin
      mem[mem_addr[5:0]]         <= mem_wdata[15:8];
      mem[mem_addr[5:0] | 6'd1]  <= mem_wdata[7:0];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: applies the request to the byte image and predicts the response.
  task automatic modelOp(input logic wr, by, sg, input logic [15:0] a, w, output exp_t e);
    int last, v;
    last    = int'(a) + (by ? 0 : 1);
    e.rdata = '0;
    e.fault = 2'b00;
    e.acc   = 0;
    if (last >= MEM_BYTES) begin
      e.fault = 2'b10;
      e.lat   = 1;
    end else if (!by && a[0]) begin
      e.fault = 2'b01;
      e.lat   = 1;
    end else if (!wr) begin
      e.lat = 2;
      if (by) begin
        v = int'(refMem[a]);
        if (sg && v >= 128) v = v - 256;
        e.rdata = v[15:0];
      end else begin
        e.rdata = {refMem[a], refMem[a + 1]};
      end
    end else if (by) begin
      refMem[a] = w[7:0];
      e.lat     = 3;
    end else begin
      refMem[a]     = w[15:8];
      refMem[a + 1] = w[7:0];
      e.lat         = 2;
    end
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      if (mem_read && mem_write) protErrs++;
      if ((mem_read || mem_write) && (mem_addr[0] || mem_addr >= 32'(MEM_BYTES))) protErrs++;
      if (mem_read || mem_write) begin
        memAccesses++;
        if (expQ.size() == 0 || expQ[0].fault != 2'b00) protErrs++;
      end
      if (!manualMode) checkOutput("req_ready", {31'd0, req_ready}, {31'd0, expQ.size() == 0});
      if (resp_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("spurious_resp", 1, 0);
        end else begin
          monEntry  = expQ.pop_front();
          lastRdata = resp_rdata;
          lastFault = resp_fault;
          lastLat   = cyc - monEntry.acc + 1;
          checkOutput("resp_rdata", {16'd0, resp_rdata}, {16'd0, monEntry.rdata});
          checkOutput("resp_fault", {30'd0, resp_fault}, {30'd0, monEntry.fault});
          checkOutput("latency", lastLat, monEntry.lat);
        end
      end
    end
  end

  // Offer one request and leave req_valid high so the next call is back-to-back.
  task automatic applyStimulus(input logic wr, by, sg, input logic [15:0] a, w);
    exp_t e;
    int   waited = 0;
    req_write  = wr;
    req_byte   = by;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = w;
    req_valid  = 1'b1;
    while (!req_ready && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (!req_ready) begin
      checkOutput("accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    modelOp(wr, by, sg, a, w, e);
    @(posedge clock);
    #1;
    e.acc = cyc;
    expQ.push_back(e);
  endtask

  task automatic waitIdle();
    int n = 0;
    req_valid = 1'b0;
    while (expQ.size() != 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (expQ.size() != 0) begin
      checkOutput("drain_timeout", expQ.size(), 0);
      expQ.delete();
    end
    @(negedge clock);
  endtask

  initial begin
    logic [7:0] before0, before1;
    int         acc0, mism;

    repeat (2) @(negedge clock);
    checkOutput("rst_req_ready", {31'd0, req_ready}, 1);
    checkOutput("rst_resp_valid", {31'd0, resp_valid}, 0);
    checkOutput("rst_resp_rdata", {16'd0, resp_rdata}, 0);
    checkOutput("rst_resp_fault", {30'd0, resp_fault}, 0);
    checkOutput("rst_mem_read", {31'd0, mem_read}, 0);
    checkOutput("rst_mem_write", {31'd0, mem_write}, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    reset_n    = 1'b1;
    manualMode = 1'b0;
    @(negedge clock);

    for (int i = 0; i < MEM_BYTES; i += 2) applyStimulus(1'b1, 1'b0, 1'b0, 16'(i), 16'($urandom));
    waitIdle();

    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000);
    waitIdle();
    checkOutput("wst_byte10", {24'd0, mem[16]}, 32'hBE);
    checkOutput("wst_byte11", {24'd0, mem[17]}, 32'hEF);
    checkOutput("wld_rdata", {16'd0, lastRdata}, 32'hBEEF);
    checkOutput("wld_latency", lastLat, 2);

    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0010, 16'h12F0);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0011, 16'h0000);
    waitIdle();
    checkOutput("bld_signed_11", {16'd0, lastRdata}, 32'hFFF0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0011, 16'h0000);
    waitIdle();
    checkOutput("bld_unsigned_11", {16'd0, lastRdata}, 32'h00F0);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0010, 16'h0000);
    waitIdle();
    checkOutput("bld_signed_10", {16'd0, lastRdata}, 32'h0012);

    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0020, 16'h1234);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0021, 16'h55AA);
    waitIdle();
    checkOutput("rmw_byte20", {24'd0, mem[32]}, 32'h12);
    checkOutput("rmw_byte21", {24'd0, mem[33]}, 32'hAA);
    checkOutput("rmw_latency", lastLat, 3);

    acc0 = memAccesses;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0013, 16'h0000);
    waitIdle();
    checkOutput("flt_align_13", {30'd0, lastFault}, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h003F, 16'h0000);
    waitIdle();
    checkOutput("flt_range_3f", {30'd0, lastFault}, 2);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000);
    waitIdle();
    checkOutput("flt_range_40", {30'd0, lastFault}, 2);
    checkOutput("flt_latency", lastLat, 1);
    checkOutput("flt_no_access", memAccesses - acc0, 0);

    // Reset lands while the word store sits in WRITE, before its memory edge.
    manualMode = 1'b1;
    before0    = mem[48];
    before1    = mem[49];
    req_write  = 1'b1;
    req_byte   = 1'b0;
    req_addr   = 16'h0030;
    req_wdata  = ~{before0, before1};
    req_valid  = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    checkOutput("rst_in_write", {31'd0, mem_write}, 1);
    reset_n = 1'b0;
    #1;
    checkOutput("rst_write_drop", {31'd0, mem_write}, 0);
    @(posedge clock);
    @(negedge clock);
    checkOutput("rst_target_hi", {24'd0, mem[48]}, {24'd0, before0});
    checkOutput("rst_target_lo", {24'd0, mem[49]}, {24'd0, before1});
    checkOutput("rst_ready_idle", {31'd0, req_ready}, 1);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clock);
      checkOutput("rst_no_resp", {31'd0, resp_valid}, 0);
    end
    manualMode = 1'b0;

    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom), 1'($urandom), 1'($urandom),
                    16'($urandom_range(0, MEM_BYTES + 7)), 16'($urandom));
      if ($urandom_range(0, 4) == 0) waitIdle();
    end
    waitIdle();

    mism = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (mem[i] !== refMem[i]) mism++;
    checkOutput("mem_image", mism, 0);
    checkOutput("bus_protocol", protErrs, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
